// File: rtl/vga_rand_tiles.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : vga_rand_tiles
// Description : Tiled random-colour generator; refills a per-row colour buffer
//               from an LFSR word during horizontal/vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rand_tiles #(
    parameter int TILE_W  = 40,
    parameter int TILE_H  = 40,
    parameter int TILES_X = 16
) (
    input  logic        i_clk,
    input  logic        i_nreset,
    input  logic [11:0] i_rand,
    input  logic        i_de,
    input  logic        i_vblank,
    input  logic        i_freeze,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b,
    output logic        o_de,
    output logic        o_busy,
    output logic        o_underrun
);

    localparam int PX_W = (TILE_W  > 1) ? $clog2(TILE_W)  : 1;
    localparam int LY_W = (TILE_H  > 1) ? $clog2(TILE_H)  : 1;
    localparam int TX_W = (TILES_X > 1) ? $clog2(TILES_X) : 1;

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_W - 1);
    localparam logic [LY_W-1:0] LY_LAST = LY_W'(TILE_H - 1);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(TILES_X - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [11:0]     tiles [TILES_X];
    logic [11:0]     colour;
    logic [PX_W-1:0] px;
    logic [TX_W-1:0] tx;
    logic [LY_W-1:0] ly;
    logic [TX_W-1:0] fi;
    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic            de_q;
    logic            vblank_q;
    logic            armed;
    logic            underrun;

    logic de_fall;
    logic vb_rise;
    logic fill_req;
    logic start;
    logic wr_en;
    logic uf_set;

    assign de_fall = de_q & ~i_de;
    assign vb_rise = i_vblank & ~vblank_q;
    // armed masks the first edge after reset so a vblank already high is not seen as a rise
    assign fill_req = armed & ~i_freeze & (vb_rise | (de_fall && ly == LY_LAST));

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fill_req) state_nxt = S_FILL;
            S_FILL:  if (i_de || fi == TX_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start  = (state == S_IDLE) && fill_req;
        wr_en  = (state == S_FILL) && !i_de;
        uf_set = (state == S_FILL) && i_de;
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            for (int i = 0; i < TILES_X; i++) begin
                tiles[i] <= '0;
            end
            colour   <= '0;
            o_de     <= 1'b0;
            px       <= '0;
            tx       <= '0;
            ly       <= '0;
            fi       <= '0;
            de_q     <= 1'b0;
            vblank_q <= 1'b0;
            armed    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            armed    <= 1'b1;
            de_q     <= i_de;
            vblank_q <= i_vblank;
            o_de     <= i_de;
            colour   <= i_de ? tiles[tx] : 12'h000;

            if (!i_de) begin
                px <= '0;
                tx <= '0;
            end else if (px == PX_LAST) begin
                px <= '0;
                if (tx != TX_LAST) tx <= tx + 1'b1;
            end else begin
                px <= px + 1'b1;
            end

            if (i_vblank) begin
                ly <= '0;
            end else if (de_fall) begin
                ly <= (ly == LY_LAST) ? '0 : ly + 1'b1;
            end

            if (start) begin
                fi <= '0;
            end else if (wr_en) begin
                fi <= fi + 1'b1;
            end

            if (wr_en) tiles[fi] <= i_rand;

            // set has priority over the vblank clear
            if (uf_set) begin
                underrun <= 1'b1;
            end else if (vb_rise) begin
                underrun <= 1'b0;
            end
        end
    end

    assign o_r        = colour[11:8];
    assign o_g        = colour[7:4];
    assign o_b        = colour[3:0];
    assign o_busy     = (state == S_FILL);
    assign o_underrun = underrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_rand_tiles.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_rand_tiles
// Description : Directed self-checking bench for vga_rand_tiles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rand_tiles;

    logic        i_clk;
    logic        i_nreset;
    logic [11:0] i_rand;
    logic        i_de;
    logic        i_vblank;
    logic        i_freeze;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;
    logic        o_de;
    logic        o_busy;
    logic        o_underrun;

    logic [11:0] colour_obs;
    logic [11:0] exp_buf [16];
    int          n_checks;
    int          n_fail;
    int          busy_act;
    int          busy_blank;
    int          first_busy;
    int          busy_total;

    assign colour_obs = {o_r, o_g, o_b};

    vga_rand_tiles #(.TILE_W(40), .TILE_H(40), .TILES_X(16)) dut (
        .i_clk      (i_clk),
        .i_nreset   (i_nreset),
        .i_rand     (i_rand),
        .i_de       (i_de),
        .i_vblank   (i_vblank),
        .i_freeze   (i_freeze),
        .o_r        (o_r),
        .o_g        (o_g),
        .o_b        (o_b),
        .o_de       (o_de),
        .o_busy     (o_busy),
        .o_underrun (o_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One active line followed by a blank; i_rand = 0x100+j on blank clock j
    task automatic run_line(input int npx, input int nblank, input bit chk);
        int t;
        busy_act   = 0;
        busy_blank = 0;
        first_busy = -1;
        for (int p = 0; p < npx; p++) begin
            i_de   = 1'b1;
            i_rand = 12'h000;
            step();
            t = p / 40;
            if (t > 15) t = 15;
            if (chk) check("pixel", {19'd0, o_de, colour_obs}, {19'd0, 1'b1, exp_buf[t]});
            if (o_busy) busy_act++;
        end
        for (int j = 0; j < nblank; j++) begin
            i_de   = 1'b0;
            i_rand = 12'h100 + 12'(j);
            step();
            if (chk && j == 0) check("blank", {19'd0, o_de, colour_obs}, 32'd0);
            if (o_busy) begin
                busy_blank++;
                if (first_busy < 0) first_busy = j;
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_nreset = 1'b0;
        i_rand   = 12'h000;
        i_de     = 1'b0;
        i_vblank = 1'b1;
        i_freeze = 1'b0;
        for (int k = 0; k < 16; k++) exp_buf[k] = 12'h000;

        // Reset state, then release with vblank already high
        #2;
        check("rst_colour", colour_obs, 0);
        check("rst_de", o_de, 0);
        check("rst_busy", o_busy, 0);
        check("rst_underrun", o_underrun, 0);
        step();
        step();
        i_nreset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("release_busy", o_busy, 0);
        end
        i_vblank = 1'b0;
        step();

        // Blank buffer shows black with o_de delayed
        run_line(640, 160, 1'b1);
        check("idle_busy", busy_act + busy_blank, 0);

        // vblank fill, freeze raised mid-fill must not abort it
        i_vblank = 1'b1;
        i_rand   = 12'h000;
        step();
        check("fill_start", o_busy, 1);
        for (int k = 0; k < 16; k++) begin
            i_rand   = 12'(k + 1);
            i_freeze = (k >= 8);
            step();
            check("fill_busy", o_busy, (k < 15) ? 1 : 0);
            exp_buf[k] = 12'(k + 1);
        end
        i_freeze = 1'b0;
        i_vblank = 1'b0;
        step();
        check("fill_done", o_busy, 0);
        run_line(640, 160, 1'b1);

        // Frozen vblank edge, then forty lines: only the 40th falling edge fills
        i_freeze = 1'b1;
        i_vblank = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("freeze_vb_busy", o_busy, 0);
        end
        i_vblank = 1'b0;
        step();
        i_freeze = 1'b0;
        busy_total = 0;
        for (int l = 0; l < 39; l++) begin
            run_line(640, 160, 1'b0);
            busy_total += busy_act + busy_blank;
        end
        check("rows_no_fill", busy_total, 0);
        run_line(640, 160, 1'b0);
        check("row40_act_busy", busy_act, 0);
        check("row40_blank_busy", busy_blank, 16);
        check("row40_first_busy", first_busy, 0);
        for (int k = 0; k < 16; k++) exp_buf[k] = 12'h100 + 12'(k + 1);
        run_line(640, 160, 1'b1);

        // Row boundary under freeze: no fill, contents held
        for (int l = 0; l < 38; l++) run_line(640, 160, 1'b0);
        i_freeze = 1'b1;
        run_line(640, 160, 1'b0);
        check("freeze_row_busy", busy_act + busy_blank, 0);
        i_freeze = 1'b0;
        run_line(640, 160, 1'b1);

        // Underrun: active video after five writes
        i_vblank = 1'b1;
        step();
        check("ur_start", o_busy, 1);
        i_vblank = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_rand = 12'hA00 + 12'(k);
            step();
            exp_buf[k] = 12'hA00 + 12'(k);
        end
        run_line(640, 160, 1'b1);
        check("ur_flag", o_underrun, 1);
        check("ur_idle", busy_act + busy_blank, 0);
        i_freeze = 1'b1;
        i_vblank = 1'b1;
        step();
        check("ur_clear", o_underrun, 0);
        check("ur_clear_busy", o_busy, 0);
        i_vblank = 1'b0;
        i_freeze = 1'b0;
        step();

        // Long line: tile index saturates on the last tile
        run_line(700, 160, 1'b1);

        // Underrun set and vblank clear on the same clock: set wins
        i_vblank = 1'b1;
        step();
        check("sw_start", o_busy, 1);
        i_vblank = 1'b0;
        i_rand   = 12'hB00;
        step();
        i_rand   = 12'hB01;
        step();
        exp_buf[0] = 12'hB00;
        exp_buf[1] = 12'hB01;
        i_vblank = 1'b1;
        i_de     = 1'b1;
        step();
        check("sw_underrun", o_underrun, 1);
        check("sw_busy", o_busy, 0);
        i_de = 1'b0;
        step();
        i_vblank = 1'b0;
        step();
        run_line(640, 160, 1'b1);

        // Reset mid-fill clears the buffer and all flags asynchronously
        i_vblank = 1'b1;
        step();
        check("mr_start", o_busy, 1);
        i_vblank = 1'b0;
        i_rand   = 12'hC00;
        step();
        i_rand   = 12'hC01;
        step();
        i_nreset = 1'b0;
        #2;
        check("mr_busy", o_busy, 0);
        check("mr_underrun", o_underrun, 0);
        check("mr_de", o_de, 0);
        step();
        i_nreset = 1'b1;
        for (int k = 0; k < 16; k++) exp_buf[k] = 12'h000;
        step();
        check("mr_release_busy", o_busy, 0);
        run_line(640, 160, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
